// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: load/store front end with a posted store
// buffer, store-to-load forwarding and a single-port dmem master.
module dmem_access_unit #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic [ADDR_W-1:0] dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wmask,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    input  logic              drain_req,
    output logic              sb_empty
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   byte_mask = 4'b0001 << a;
            2'b01:   byte_mask = 4'b0011 << a;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b001, 3'b101: is_misaligned = a[0];
            3'b010:         is_misaligned = (a != 2'b00);
            default:        is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = 16'(w >> {a[1], 4'b0000});
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b100:  extend = {24'h0, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b101:  extend = {16'h0, h};
            default: extend = w;
        endcase
    endfunction

    state_t             state, state_n;
    logic [WA_W-1:0]    sb_addr [SB_DEPTH];
    logic [31:0]        sb_data [SB_DEPTH];
    logic [3:0]         sb_mask [SB_DEPTH];
    logic [PTR_W-1:0]   head, tail, yng_idx;
    logic [CNT_W-1:0]   count, ld_older, older_n;

    logic               ld_valid, ld_search;
    logic [WA_W-1:0]    ld_word;
    logic [2:0]         ld_f3;
    logic [1:0]         ld_a;
    logic [3:0]         ld_mask;

    logic               rsp_q_valid, rsp_q_mis;
    logic [31:0]        rsp_q_data;

    logic overlap, fwd_hit, ld_issue, st_issue, pop, ld_done, full;
    logic req_mis, accept, acc_ld, acc_st, acc_mis;

    // Only entries older than the held load take part in the search; ld_older
    // counts them from the head and shrinks as they drain.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        older_n = ld_search ? count : ld_older;
        overlap = 1'b0;
        yng_idx = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CNT_W'(i) < older_n && sb_addr[head + PTR_W'(i)] == ld_word &&
                (sb_mask[head + PTR_W'(i)] & ld_mask) != 4'b0000) begin
                overlap = 1'b1;
                yng_idx = head + PTR_W'(i);
            end
        end
    end

    assign fwd_hit  = ld_valid && ld_search && overlap && ((sb_mask[yng_idx] & ld_mask) == ld_mask);
    assign ld_issue = ld_valid && !fwd_hit && !overlap && state == IDLE;
    assign st_issue = state == IDLE && !ld_issue && count != '0;
    assign pop      = state == ST_WAIT && dmem_resp;
    assign ld_done  = state == LD_WAIT && dmem_resp;
    assign full     = count == CNT_W'(SB_DEPTH);
    assign sb_empty = count == '0;

    // Nothing is accepted in a load-completion cycle so that the load's
    // response never collides with a next-cycle store/fault response.
    always_comb begin
        req_ready = 1'b0;
        if (!rst && !ld_done) begin
            if (req_load)       req_ready = !ld_valid && state == IDLE && !drain_req;
            else if (req_store) req_ready = !full || pop;
            else                req_ready = 1'b1;
        end
    end

    assign req_mis = (req_load || req_store) && is_misaligned(req_funct3, req_addr[1:0]);
    assign accept  = req_valid && req_ready;
    assign acc_ld  = accept && req_load && !req_mis;
    assign acc_st  = accept && req_store && !req_mis;
    assign acc_mis = accept && req_mis;

    // NOTE: buffer storage has no reset; count/head/tail define which entries are live.
    always_ff @(posedge clk) begin
        if (acc_st) begin
            sb_addr[tail] <= req_addr[ADDR_W-1:2];
            sb_data[tail] <= req_wdata << {req_addr[1:0], 3'b000};
            sb_mask[tail] <= byte_mask(req_funct3, req_addr[1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ld_valid    <= 1'b0;
            ld_search   <= 1'b0;
            ld_word     <= '0;
            ld_f3       <= 3'b000;
            ld_a        <= 2'b00;
            ld_mask     <= 4'b0000;
            ld_older    <= '0;
            rsp_q_valid <= 1'b0;
            rsp_q_mis   <= 1'b0;
            rsp_q_data  <= 32'h0;
        end else begin
            if (acc_st) tail <= tail + PTR_W'(1);
            if (pop)    head <= head + PTR_W'(1);
            count <= count + CNT_W'(acc_st) - CNT_W'(pop);

            ld_search <= acc_ld;
            if (acc_ld) begin
                ld_valid <= 1'b1;
                ld_word  <= req_addr[ADDR_W-1:2];
                ld_f3    <= req_funct3;
                ld_a     <= req_addr[1:0];
                ld_mask  <= byte_mask(req_funct3, req_addr[1:0]);
            end else if (fwd_hit || ld_done) begin
                ld_valid <= 1'b0;
            end
            ld_older <= older_n - CNT_W'(pop && older_n != '0);

            rsp_q_valid <= acc_st || acc_mis || ld_done;
            rsp_q_mis   <= acc_mis;
            rsp_q_data  <= ld_done ? extend(dmem_rdata, ld_f3, ld_a) : 32'h0;
        end
    end

    assign rsp_valid      = rsp_q_valid || fwd_hit;
    assign rsp_rdata      = fwd_hit ? extend(sb_data[yng_idx], ld_f3, ld_a) : rsp_q_data;
    assign rsp_misaligned = rsp_q_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ld_issue) state_n = LD_WAIT;
                     else if (st_issue) state_n = ST_WAIT;
            LD_WAIT: if (dmem_resp) state_n = IDLE;
            ST_WAIT: if (dmem_resp) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are decoded from state and held registers, so they stay stable
    // through a wait and drop as soon as reset clears the state register.
    always_comb begin
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = 32'h0;
        dmem_wmask   = 4'b0000;
        if (ld_issue || state == LD_WAIT) begin
            dmem_read    = 1'b1;
            dmem_address = {ld_word, 2'b00};
        end else if (st_issue || state == ST_WAIT) begin
            dmem_write   = 1'b1;
            dmem_address = {sb_addr[head], 2'b00};
            dmem_wdata   = sb_data[head];
            dmem_wmask   = sb_mask[head];
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a scoreboard queue of expected responses
// checked by a negedge monitor, plus a small dmem model driven from the stimulus.
module tb_dmem_access_unit;
    localparam int SB_DEPTH = 4;
    localparam int ADDR_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_load, req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_misaligned;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_read, dmem_write;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp, drain_req, sb_empty;

    dmem_access_unit #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .dmem_address(dmem_address),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .drain_req(drain_req), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          due;   // expected monitor cycle, -1 when latency is free
    } exp_t;

    exp_t              sb_q[$];
    logic [31:0]       mem [int unsigned];
    int                cyc = 0;
    int                n_cmp = 0, n_fail = 0;
    int                n_rd = 0, n_wr = 0, n_rd_cyc = 0, n_wr_cyc = 0, n_rsp = 0;
    int                rd_wr_snap = 0;
    logic [31:0]       last_wdata = 32'h0;
    logic [3:0]        last_wmask = 4'h0;
    bit                auto_resp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned k);
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    // dmem model: completes whatever strobe is currently presented.
    task automatic give_resp();
        int unsigned k;
        logic [31:0] w;
        k = dmem_address[31:2];
        if (dmem_read) begin
            dmem_rdata = mem_rd(k);
            rd_wr_snap = n_wr;
            n_rd++;
        end else if (dmem_write) begin
            w = mem_rd(k);
            for (int b = 0; b < 4; b++)
                if (dmem_wmask[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
            mem[k]     = w;
            last_wdata = dmem_wdata;
            last_wmask = dmem_wmask;
            n_wr++;
        end
        dmem_resp = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (dmem_resp) dmem_resp = 1'b0;
        else if (auto_resp && (dmem_read || dmem_write)) give_resp();
    endtask

    task automatic send(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit exp_rsp, input logic [31:0] exp_data,
                        input bit exp_mis, input bit timed);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3;  req_addr = addr; req_wdata = wd;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (exp_rsp) sb_q.push_back('{data: exp_data, mis: exp_mis, due: timed ? cyc + 1 : -1});
                tick();
                req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
                return;
            end
            tick();
        end
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: addr 0x%08h never accepted", addr);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && sb_empty && !dmem_read && !dmem_write && !dmem_resp) return;
            tick();
        end
        n_cmp++; n_fail++;
        $display("FAIL %s: unit did not go idle, pending=%0d", name, sb_q.size());
    endtask

    initial begin
        int rd0, wr0, rsp0;
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = 32'h0;
        dmem_rdata = 32'h0; dmem_resp = 1'b0; drain_req = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (dmem_read)  n_rd_cyc++;
                if (dmem_write) n_wr_cyc++;
                if (!rst && rsp_valid) begin
                    n_rsp++;
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_rsp: data 0x%08h mis %0b at cycle %0d, none expected",
                                 rsp_rdata, rsp_misaligned, cyc);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.data);
                        check("rsp_misaligned", {31'b0, rsp_misaligned}, {31'b0, e.mis});
                        if (e.due >= 0) check("rsp_cycle", 32'(cyc), 32'(e.due));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_strobes", {30'b0, dmem_read, dmem_write}, 32'h0);
        check("rst_sb_empty", {31'b0, sb_empty}, 32'h1);
        tick();
        rst = 1'b0;
        tick();

        // 1: store then load of the same word with dmem stalled -> forward hit
        auto_resp = 1'b0;
        rd0 = n_rd_cyc;
        send(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0, 0, 1);
        send(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 1);
        repeat (3) tick();
        @(negedge clk);
        check("t1_write_held", {31'b0, dmem_write}, 32'h1);
        check("t1_no_read", 32'(n_rd_cyc), 32'(rd0));
        auto_resp = 1'b1;
        wait_idle("t1_drain");
        check("t1_mem", mem_rd(32'h100 >> 2), 32'hDEADBEEF);

        // 2: signed forward of a byte, then unsigned load of it from dmem
        auto_resp = 1'b0;
        send(0, 1, 3'b000, 32'h203, 32'h00000080, 1, 32'h0, 0, 1);
        send(1, 0, 3'b000, 32'h203, 32'h0, 1, 32'hFFFFFF80, 0, 1);
        auto_resp = 1'b1;
        send(1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h00000080, 0, 0);
        wait_idle("t2_drain");

        // 3: partial overlap -> the store drains before the load reads dmem
        mem[32'h300 >> 2] = 32'h11223344;
        auto_resp = 1'b0;
        wr0 = n_wr;
        send(0, 1, 3'b000, 32'h301, 32'h000000AB, 1, 32'h0, 0, 1);
        send(1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h1122AB44, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        check("t3_read_blocked", {31'b0, dmem_read}, 32'h0);
        auto_resp = 1'b1;
        wait_idle("t3_drain");
        check("t3_wmask", {28'b0, last_wmask}, 32'h2);
        check("t3_wdata", last_wdata, 32'h0000AB00);
        check("t3_write_first", 32'(rd_wr_snap), 32'(wr0 + 1));

        // 4: fill the buffer, then a pop frees the slot for a same-cycle store
        auto_resp = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            send(0, 1, 3'b010, 32'h400 + 32'(4 * i), 32'hA0000000 + 32'(i), 1, 32'h0, 0, 1);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h410; req_wdata = 32'hA0000004;
        @(negedge clk);
        check("t4_full_ready", {31'b0, req_ready}, 32'h0);
        tick();
        give_resp();
        @(negedge clk);
        check("t4_pop_ready", {31'b0, req_ready}, 32'h1);
        if (req_ready) sb_q.push_back('{data: 32'h0, mis: 1'b0, due: cyc + 1});
        tick();
        req_addr = 32'h414; req_wdata = 32'hA0000005;
        @(negedge clk);
        check("t4_still_full", {31'b0, req_ready}, 32'h0);
        check("t4_pop_data", last_wdata, 32'hA0000000);
        req_valid = 1'b0; req_store = 1'b0;
        auto_resp = 1'b1;
        wait_idle("t4_drain");
        check("t4_mem_first", mem_rd(32'h400 >> 2), 32'hA0000000);
        check("t4_mem_last", mem_rd(32'h410 >> 2), 32'hA0000004);
        check("t4_no_extra", mem_rd(32'h414 >> 2), 32'h0);

        // 5: misaligned ops fault with no memory effect; fence blocks loads
        rd0 = n_rd_cyc; wr0 = n_wr_cyc;
        send(1, 0, 3'b001, 32'h101, 32'h0, 1, 32'h0, 1, 1);
        send(0, 1, 3'b010, 32'h102, 32'h12345678, 1, 32'h0, 1, 1);
        send(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1, 1);
        repeat (2) tick();
        @(negedge clk);
        check("t5_no_read", 32'(n_rd_cyc), 32'(rd0));
        check("t5_no_write", 32'(n_wr_cyc), 32'(wr0));
        check("t5_sb_empty", {31'b0, sb_empty}, 32'h1);
        check("t5_mem", mem_rd(32'h100 >> 2), 32'hDEADBEEF);
        tick();
        drain_req = 1'b1;
        req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        check("t5_fence_ready", {31'b0, req_ready}, 32'h0);
        req_valid = 1'b0; req_load = 1'b0;
        tick();
        drain_req = 1'b0;

        // 6: reset in the middle of LD_WAIT with two stores buffered
        auto_resp = 1'b0;
        send(1, 0, 3'b010, 32'h600, 32'h0, 0, 32'h0, 0, 0);
        send(0, 1, 3'b010, 32'h500, 32'h55555555, 1, 32'h0, 0, 1);
        send(0, 1, 3'b010, 32'h504, 32'h66666666, 1, 32'h0, 0, 1);
        repeat (2) tick();
        @(negedge clk);
        check("t6_read_held", {31'b0, dmem_read}, 32'h1);
        check("t6_sb_busy", {31'b0, sb_empty}, 32'h0);
        check("t6_pending", 32'(sb_q.size()), 32'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_read", {31'b0, dmem_read}, 32'h0);
        check("t6_rst_empty", {31'b0, sb_empty}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd0 = n_rd_cyc; rsp0 = n_rsp;
        auto_resp = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("t6_no_rsp", 32'(n_rsp), 32'(rsp0));
        check("t6_no_read", 32'(n_rd_cyc), 32'(rd0));
        check("t6_mem_untouched", mem_rd(32'h500 >> 2), 32'h0);

        wait_idle("final_idle");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
